// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline.
// Widths, stage-state enum and the MEM/WB field bundle.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } stage_t;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memToReg;
    logic [DATA_W-1:0]     readData;
    logic [DATA_W-1:0]     aluResult;
    logic [REG_ADDR_W-1:0] writeReg;
  } mem_wb_t;

endpackage

// File: rtl/bus_watchdog.sv
// Access watchdog: start clears and arms, ack disarms.
// Ports: clk, rstN, start, ack in; expire out (TIMEOUT=0 disables).
module bus_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rstN,
  input  logic start,
  input  logic ack,
  output logic expire
);

  if (TIMEOUT == 0) begin : gOff
    logic unused;
    assign unused = &{1'b0, clk, rstN, start, ack};
    assign expire = 1'b0;
  end else begin : gOn
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;
    logic          running;

    // Fires on the TIMEOUT-th waiting cycle; an ack that
    // cycle takes precedence.
    assign expire = running && !ack && (count == LAST);

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        count   <= '0;
        running <= 1'b0;
      end else if (start) begin
        count   <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (ack || expire) begin
          running <= 1'b0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory req/ack access, stall, MEM/WB registers.
// Ports: ex* from EX/MEM, mem* bus, wb* to write-back, stall, busErr.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic                  exMemWrite,
  input  logic                  exRegWrite,
  input  logic                  exMemToReg,
  input  logic [DATA_W-1:0]     exAluResult,
  input  logic [DATA_W-1:0]     exWriteData,
  input  logic [REG_ADDR_W-1:0] exWriteReg,
  output logic                  stall,
  output logic                  memReq,
  output logic                  memWe,
  output logic [DATA_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memWdata,
  input  logic                  memAck,
  input  logic [DATA_W-1:0]     memRdata,
  output logic                  wbValid,
  output logic                  wbRegWrite,
  output logic                  wbMemToReg,
  output logic [DATA_W-1:0]     wbReadData,
  output logic [DATA_W-1:0]     wbAluResult,
  output logic [REG_ADDR_W-1:0] wbWriteReg,
  output logic                  busErr
);

  stage_t                state;
  logic [DATA_W-1:0]     addrQ;
  logic [DATA_W-1:0]     wdataQ;
  logic                  weQ;
  logic                  rdQ;
  logic                  regWrQ;
  logic                  m2rQ;
  logic [REG_ADDR_W-1:0] wrRegQ;

  logic memOp;
  logic accept;
  logic ack;
  logic expire;

  assign memOp  = exMemRead | exMemWrite;
  assign accept = (state == IDLE) && exValid && memOp;
  assign ack    = (state == ACCESS) && memAck;

  assign stall = rstN &&
    (accept ||
     ((state == ACCESS) && !memAck && !expire));

  assign memReq   = (state == ACCESS);
  assign memWe    = memReq && weQ;
  assign memAddr  = addrQ;
  assign memWdata = wdataQ;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWdog (
    .clk   (clk),
    .rstN  (rstN),
    .start (accept),
    .ack   (ack),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      addrQ       <= '0;
      wdataQ      <= '0;
      weQ         <= 1'b0;
      rdQ         <= 1'b0;
      regWrQ      <= 1'b0;
      m2rQ        <= 1'b0;
      wrRegQ      <= '0;
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbReadData  <= '0;
      wbAluResult <= '0;
      wbWriteReg  <= '0;
      busErr      <= 1'b0;
    end else begin
      wbValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            // Read+write together is a store.
            addrQ  <= exAluResult;
            wdataQ <= exWriteData;
            weQ    <= exMemWrite;
            rdQ    <= exMemRead & ~exMemWrite;
            regWrQ <= exRegWrite;
            m2rQ   <= exMemToReg & ~exMemWrite;
            wrRegQ <= exWriteReg;
            state  <= ACCESS;
          end else if (exValid) begin
            wbValid     <= 1'b1;
            wbRegWrite  <= exRegWrite;
            wbMemToReg  <= exMemToReg;
            wbAluResult <= exAluResult;
            wbWriteReg  <= exWriteReg;
          end
        end
        ACCESS: begin
          if (ack || expire) begin
            wbValid     <= 1'b1;
            wbRegWrite  <= regWrQ & ack;
            wbMemToReg  <= m2rQ;
            wbAluResult <= addrQ;
            wbWriteReg  <= wrRegQ;
            if (ack && rdQ) begin
              wbReadData <= memRdata;
            end
            if (!ack) begin
              busErr <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a WB scoreboard.
// DUT built with TIMEOUT=4.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exValid, exMemRead, exMemWrite;
  logic        exRegWrite, exMemToReg;
  logic [15:0] exAluResult, exWriteData;
  logic [2:0]  exWriteReg;
  logic        stall, memReq, memWe;
  logic [15:0] memAddr, memWdata;
  logic        memAck;
  logic [15:0] memRdata;
  logic        wbValid, wbRegWrite, wbMemToReg;
  logic [15:0] wbReadData, wbAluResult;
  logic [2:0]  wbWriteReg;
  logic        busErr;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [15:0] rd;
    logic [15:0] alu;
    logic [2:0]  wr;
  } wbExp_t;

  wbExp_t      sb[$];
  logic [15:0] lastRd;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rstN(rstN),
    .exValid(exValid), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exRegWrite(exRegWrite),
    .exMemToReg(exMemToReg), .exAluResult(exAluResult),
    .exWriteData(exWriteData), .exWriteReg(exWriteReg),
    .stall(stall), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata),
    .wbValid(wbValid), .wbRegWrite(wbRegWrite),
    .wbMemToReg(wbMemToReg), .wbReadData(wbReadData),
    .wbAluResult(wbAluResult), .wbWriteReg(wbWriteReg),
    .busErr(busErr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    exValid = 0; exMemRead = 0; exMemWrite = 0;
    exRegWrite = 0; exMemToReg = 0;
    exAluResult = 0; exWriteData = 0; exWriteReg = 0;
    memAck = 0; memRdata = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic rw, input logic m2r,
                      input logic [15:0] rd,
                      input logic [15:0] alu,
                      input logic [2:0] wr);
    wbExp_t e;
    e.rw = rw; e.m2r = m2r; e.rd = rd;
    e.alu = alu; e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic op(input logic rd, input logic wr,
                    input logic rw, input logic m2r,
                    input logic [15:0] a,
                    input logic [15:0] d,
                    input logic [2:0] r);
    clr();
    exValid = 1; exMemRead = rd; exMemWrite = wr;
    exRegWrite = rw; exMemToReg = m2r;
    exAluResult = a; exWriteData = d; exWriteReg = r;
  endtask

  // Scoreboard: every wbValid pulse consumes one entry.
  always @(negedge clk) begin
    if (rstN === 1'b1 && wbValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wbUnexpected", 32'(wbValid), 32'd0);
      end else begin
        wbExp_t e;
        e = sb.pop_front();
        chk("wbRegWrite", 32'(wbRegWrite), 32'(e.rw));
        chk("wbMemToReg", 32'(wbMemToReg), 32'(e.m2r));
        chk("wbReadData", 32'(wbReadData), 32'(e.rd));
        chk("wbAluResult", 32'(wbAluResult), 32'(e.alu));
        chk("wbWriteReg", 32'(wbWriteReg), 32'(e.wr));
      end
    end
  end

  initial begin
    rstN = 0;
    lastRd = 16'h0;
    clr();
    smp();
    chk("rstStall", 32'(stall), 0);
    chk("rstMemReq", 32'(memReq), 0);
    chk("rstWbValid", 32'(wbValid), 0);
    chk("rstBusErr", 32'(busErr), 0);
    chk("rstMemAddr", 32'(memAddr), 0);
    chk("rstWbAlu", 32'(wbAluResult), 0);
    nxt();
    rstN = 1;
    nxt();

    // ALU ops back to back
    op(0, 0, 1, 0, 16'h1234, 16'h0, 3'd3);
    push(1, 0, lastRd, 16'h1234, 3'd3);
    smp();
    chk("aluStall0", 32'(stall), 0);
    nxt();
    op(0, 0, 1, 0, 16'h5678, 16'h0, 3'd5);
    push(1, 0, lastRd, 16'h5678, 3'd5);
    smp();
    chk("aluValid1", 32'(wbValid), 1);
    chk("aluStall1", 32'(stall), 0);
    nxt();
    clr();
    smp();
    chk("aluValid2", 32'(wbValid), 1);
    chk("aluRes2", 32'(wbAluResult), 32'h5678);
    nxt();
    smp();
    chk("aluValidOff", 32'(wbValid), 0);

    // Zero-wait load
    nxt();
    op(1, 0, 1, 1, 16'h0040, 16'h0, 3'd2);
    push(1, 1, 16'hBEEF, 16'h0040, 3'd2);
    lastRd = 16'hBEEF;
    smp();
    chk("ldStall0", 32'(stall), 1);
    chk("ldReq0", 32'(memReq), 0);
    nxt();
    clr();
    memAck = 1; memRdata = 16'hBEEF;
    smp();
    chk("ldReq1", 32'(memReq), 1);
    chk("ldAddr1", 32'(memAddr), 32'h0040);
    chk("ldWe1", 32'(memWe), 0);
    chk("ldStall1", 32'(stall), 0);
    chk("ldValid1", 32'(wbValid), 0);
    nxt();
    clr();
    smp();
    chk("ldValid2", 32'(wbValid), 1);
    chk("ldReq2", 32'(memReq), 0);

    // Store with 3 wait states; ack meets watchdog limit
    nxt();
    op(0, 1, 0, 0, 16'h0010, 16'h00AA, 3'd1);
    push(0, 0, lastRd, 16'h0010, 3'd1);
    smp();
    chk("stStall0", 32'(stall), 1);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      clr();
      memAck = (i == 4);
      smp();
      chk("stReq", 32'(memReq), 1);
      chk("stWe", 32'(memWe), 1);
      chk("stAddr", 32'(memAddr), 32'h0010);
      chk("stWdata", 32'(memWdata), 32'h00AA);
      chk("stStall", 32'(stall), 32'(i != 4));
    end
    nxt();
    clr();
    smp();
    chk("stValid", 32'(wbValid), 1);
    chk("stBusErr", 32'(busErr), 0);
    chk("stReqDrop", 32'(memReq), 0);

    // Timeout
    nxt();
    op(1, 0, 1, 1, 16'h0080, 16'h0, 3'd4);
    push(0, 1, lastRd, 16'h0080, 3'd4);
    smp();
    for (int i = 1; i <= 4; i++) begin
      nxt();
      clr();
      smp();
      chk("toReq", 32'(memReq), 1);
      chk("toStall", 32'(stall), 32'(i != 4));
      chk("toErrPre", 32'(busErr), 0);
    end
    nxt();
    smp();
    chk("toValid", 32'(wbValid), 1);
    chk("toBusErr", 32'(busErr), 1);
    chk("toReqOff", 32'(memReq), 0);

    // Load after timeout; busErr sticky
    nxt();
    op(1, 0, 1, 1, 16'h0042, 16'h0, 3'd6);
    push(1, 1, 16'h1111, 16'h0042, 3'd6);
    lastRd = 16'h1111;
    nxt();
    clr();
    memAck = 1; memRdata = 16'h1111;
    nxt();
    clr();
    smp();
    chk("ld2Valid", 32'(wbValid), 1);
    chk("ld2BusErr", 32'(busErr), 1);

    // Read+write together -> store
    nxt();
    op(1, 1, 0, 1, 16'h0020, 16'h0055, 3'd7);
    push(0, 0, lastRd, 16'h0020, 3'd7);
    nxt();
    clr();
    memAck = 1; memRdata = 16'hCAFE;
    smp();
    chk("rwWe", 32'(memWe), 1);
    chk("rwWdata", 32'(memWdata), 32'h0055);
    nxt();
    clr();
    smp();
    chk("rwValid", 32'(wbValid), 1);
    chk("rwM2r", 32'(wbMemToReg), 0);

    // Spurious ack in IDLE
    for (int i = 0; i < 2; i++) begin
      nxt();
      clr();
      memAck = 1; memRdata = 16'hDEAD;
      smp();
      chk("spReq", 32'(memReq), 0);
      chk("spStall", 32'(stall), 0);
    end
    nxt();
    clr();
    smp();
    chk("spValid", 32'(wbValid), 0);
    chk("spRdata", 32'(wbReadData), 32'(lastRd));
    chk("spAlu", 32'(wbAluResult), 32'h0020);

    // Reset during wait state 2
    nxt();
    op(1, 0, 1, 1, 16'h0060, 16'h0, 3'd2);
    push(1, 1, 16'h9999, 16'h0060, 3'd2);
    nxt();
    clr();
    smp();
    chk("rmReq1", 32'(memReq), 1);
    nxt();
    smp();
    chk("rmReq2", 32'(memReq), 1);
    #1;
    rstN = 0;
    #1;
    chk("rmReq", 32'(memReq), 0);
    chk("rmStall", 32'(stall), 0);
    chk("rmValid", 32'(wbValid), 0);
    chk("rmBusErr", 32'(busErr), 0);
    sb.delete();
    lastRd = 16'h0;
    nxt();
    rstN = 1;

    // Load with one wait state after reset
    nxt();
    op(1, 0, 1, 1, 16'h0044, 16'h0, 3'd1);
    push(1, 1, 16'h2222, 16'h0044, 3'd1);
    lastRd = 16'h2222;
    nxt();
    clr();
    smp();
    chk("pr1Stall", 32'(stall), 1);
    nxt();
    memAck = 1; memRdata = 16'h2222;
    smp();
    chk("pr2Addr", 32'(memAddr), 32'h0044);
    chk("pr2Stall", 32'(stall), 0);
    nxt();
    clr();
    smp();
    chk("prValid", 32'(wbValid), 1);
    chk("prRdata", 32'(wbReadData), 32'h2222);
    chk("prBusErr", 32'(busErr), 0);

    nxt();
    smp();
    chk("sbEmpty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

- Memory-access stage of the 16-bit CPU pipeline, sitting between the EX/MEM boundary and the write-back select.
- Issues load/store transactions to the data memory over a req/ack handshake and stalls the upstream pipeline while a transaction is outstanding.
- Registers the MEM/WB pipeline fields consumed by the write-back select: read data, ALU result, memToReg, regWrite, destination register.
- A watchdog aborts accesses that are never acknowledged.

## Interface
- DATA_W, 16, data/address width
- REG_ADDR_W, 3, register-file index width
- TIMEOUT, 15, max cycles in ACCESS without ack before abort; 0 disables the watchdog
- clk  in  1  rising-edge clock
- rstN  in  1  reset; asynchronous, active-low
- exValid  in  1  EX/MEM holds a valid instruction
- exMemRead, exMemWrite, exRegWrite, exMemToReg  in  1 each  control from EX/MEM
- exAluResult  in  DATA_W  ALU result / memory address
- exWriteData  in  DATA_W  store data
- exWriteReg  in  REG_ADDR_W  destination register
- stall  out  1  hold EX/MEM and earlier stages
- memReq, memWe  out  1 each  memory request, write enable
- memAddr, memWdata  out  DATA_W  memory address, store data
- memAck  in  1  memory completion strobe, one cycle
- memRdata  in  DATA_W  load data, valid with memAck
- wbValid, wbRegWrite, wbMemToReg  out  1 each  MEM/WB control
- wbReadData, wbAluResult  out  DATA_W  MEM/WB data
- wbWriteReg  out  REG_ADDR_W  MEM/WB destination
- busErr  out  1  sticky: an access timed out

## Operation

**States:** IDLE, ACCESS.

**IDLE**
- exValid=1, not a memory op:
  - Next edge loads the WB registers from the ex* fields (wbReadData keeps its old value) and sets wbValid=1.
  - stall=0.
- exValid=1, memory op (exMemRead|exMemWrite):
  - stall=1 combinationally.
  - Next edge latches addr, wdata, we and control, goes to ACCESS, sets wbValid=0.
- exValid=0: wbValid=0 next edge.

**ACCESS**
- memReq=1; memAddr, memWdata, memWe held stable until ack.
- stall = !memAck.
- On memAck:
  - Load the WB registers from the latched fields; wbReadData=memRdata on a read.
  - wbValid=1; return to IDLE.
- Watchdog timeout:
  - wbValid=1 with wbRegWrite forced 0.
  - busErr set.
  - stall=0 that cycle; return to IDLE.

**Priority and corner cases**
- exMemRead and exMemWrite both 1: treated as a store, memWe=1, wbMemToReg forced 0.
- memAck while in IDLE is ignored.
- memAck and timeout in the same cycle: the ack wins and busErr is unchanged.
- busErr clears only on reset.

## Timing

**Reset values:** every output is 0, state is IDLE, and the watchdog count is 0. Reset takes effect asynchronously, including mid-ACCESS: memReq drops immediately and the transaction is abandoned.

**Latency**
- Non-memory op: wbValid the cycle after acceptance (1 cycle).
- Memory op accepted at cycle 0:
  - memReq is asserted from cycle 1.
  - If memAck arrives at cycle 1+N (N≥0 wait cycles), wbValid is at cycle 2+N and stall is high for cycles 0..N.
- Throughput with zero-wait memory: one memory op every 2 cycles; one non-memory op per cycle.

**Handshake:** memReq stays high until the edge on which memAck is sampled, then drops for at least one cycle. Back-to-back requests are never issued.

**Watchdog**
- Counter width is $clog2(TIMEOUT+1).
- It counts cycles in ACCESS and is cleared on entry.
- Abort fires in the cycle where count == TIMEOUT-1 with no ack, i.e. the access is abandoned after TIMEOUT cycles of memReq.

**WB registers:** wbValid is high for exactly one cycle per completed instruction. The WB data registers hold their values when wbValid=0.

## Structure
- Shared package cpu_pkg holds:
  - the DATA_W and REG_ADDR_W defaults;
  - the stage-state enum (IDLE, ACCESS);
  - the MEM/WB field bundle type, shared with the write-back select.
- Sub-module bus_watchdog holds the TIMEOUT counter, with ports start, ack, expire. It is reusable for the instruction-fetch port.
- FSM, latch registers and MEM/WB registers stay in mem_wb_stage.

## Test plan
- **ALU op:** exValid=1, exAluResult=16'h1234, exRegWrite=1, exWriteReg=3 -> next cycle wbValid=1, wbAluResult=16'h1234, wbMemToReg=0, stall never asserted.
- **Zero-wait load:** exMemRead=1, exMemToReg=1, addr 16'h0040; memAck with memRdata=16'hBEEF on the first memReq cycle -> memAddr=16'h0040, stall high 1 cycle, wbReadData=16'hBEEF, wbValid at cycle 2.
- **Store with 3 wait states:** exMemWrite=1, addr 16'h0010, data 16'h00AA -> memWe=1, memAddr and memWdata stable for 4 cycles, stall high 4 cycles, wbValid one cycle after the ack with wbRegWrite=0.
- **Timeout:** TIMEOUT=4, no memAck -> memReq high 4 cycles, then wbValid=1, wbRegWrite=0, busErr=1 and sticky through a subsequent successful load.
- **Reset mid-ACCESS:** rstN low during wait state 2 -> memReq, stall, wbValid and busErr are 0 immediately. After release, a new load completes normally.
- **Corner cases:** both read and write asserted -> store issued with wbMemToReg=0. A spurious memAck in IDLE -> no output change.
